// File: rtl/fht_stage_seq_pkg.sv
// Shared constants and types for the FHT stage sequencer.
// Sizes here are the defaults used by fht_stage_seq.
package fht_stage_seq_pkg;

  localparam int FHT_N_LOG2  = 4;
  localparam int FHT_RAM_LAT = 1;
  localparam int FHT_S_BIT   = 3;
  localparam int FHT_PIPE    = FHT_RAM_LAT + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fht_stage_seq_delay.sv
// Fixed-depth shift register used to align write-back
// strobe/addresses with the butterfly output.
module fht_delay_line #(
  parameter int W     = 9,
  parameter int DEPTH = 3
) (
  input  logic         iCLK,
  input  logic         iRESET,
  input  logic [W-1:0] iDATA,
  output logic [W-1:0] oDATA
);

  logic [W-1:0] sr [DEPTH];

  // shift one stage per clock; reset flushes pending entries
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= iDATA;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign oDATA = sr[DEPTH-1];

endmodule

// File: rtl/fht_stage_seq.sv
// Per-stage FHT sequencer: issues butterfly read/twiddle
// addresses and the matching delayed write-back.
module fht_stage_seq
  import fht_stage_seq_pkg::*;
#(
  parameter int N_LOG2  = FHT_N_LOG2,
  parameter int RAM_LAT = FHT_RAM_LAT,
  parameter int S_BIT   = FHT_S_BIT
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic [S_BIT-1:0]  iSTAGE,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR,
  output logic              oRD_EN,
  output logic              oRD_BANK,
  output logic [N_LOG2-1:0] oRD_ADDR_0,
  output logic [N_LOG2-1:0] oRD_ADDR_1,
  output logic [N_LOG2-1:0] oRD_ADDR_2,
  output logic [N_LOG2-2:0] oTW_ADDR,
  output logic              oWR_EN,
  output logic [N_LOG2-1:0] oWR_ADDR_0,
  output logic [N_LOG2-1:0] oWR_ADDR_1
);

  localparam int PIPE = RAM_LAT + 2;
  localparam int NB   = 1 << (N_LOG2 - 1);
  localparam int PW   = $clog2(PIPE + 1);
  localparam int TW   = N_LOG2 - 1;
  localparam int DW   = 1 + 2 * N_LOG2;

  state_t state_q, state_d;
  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic [PW-1:0]     drn_q, drn_d;
  logic [S_BIT-1:0]  stage_q;

  logic              accept, bad, issue;
  logic [S_BIT-1:0]  s_sel, sh;
  logic [N_LOG2-1:0] j_sel, half, mask, k, base;
  logic [N_LOG2-1:0] x0, x1, x2;
  logic [TW-1:0]     tw_v;
  logic [DW-1:0]     dl_q;

  // next state, issue decision and butterfly index select
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    accept  = 1'b0;
    bad     = 1'b0;
    issue   = 1'b0;
    s_sel   = stage_q;
    j_sel   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          if (iSTAGE >= S_BIT'(N_LOG2)) begin
            bad = 1'b1;
          end else begin
            accept  = 1'b1;
            issue   = 1'b1;
            s_sel   = iSTAGE;
            cnt_d   = N_LOG2'(1);
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == N_LOG2'(NB)) begin
          drn_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          issue = 1'b1;
          j_sel = cnt_q;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drn_q == PW'(PIPE - 1)) state_d = ST_DONE;
        else drn_d = drn_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  // butterfly address arithmetic: shifts and masks only
  always_comb begin
    half = N_LOG2'(1) << s_sel;
    mask = half - 1'b1;
    k    = j_sel & mask;
    base = (j_sel >> s_sel) << (s_sel + 1'b1);
    x0   = base + k;
    x1   = base + half + k;
    x2   = base + half + ((half - k) & mask);
    sh   = S_BIT'(N_LOG2 - 1) - s_sel;
    tw_v = TW'(k << sh);
  end

  // control state and registered read-side outputs
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      drn_q      <= '0;
      stage_q    <= '0;
      oERR       <= 1'b0;
      oRD_EN     <= 1'b0;
      oRD_BANK   <= 1'b0;
      oRD_ADDR_0 <= '0;
      oRD_ADDR_1 <= '0;
      oRD_ADDR_2 <= '0;
      oTW_ADDR   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drn_q      <= drn_d;
      if (accept) stage_q <= iSTAGE;
      oERR       <= bad;
      oRD_EN     <= issue;
      oRD_BANK   <= issue & s_sel[0];
      oRD_ADDR_0 <= issue ? x0 : '0;
      oRD_ADDR_1 <= issue ? x1 : '0;
      oRD_ADDR_2 <= issue ? x2 : '0;
      oTW_ADDR   <= issue ? tw_v : '0;
    end
  end

  fht_delay_line #(
    .W     (DW),
    .DEPTH (PIPE)
  ) u_dly (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iDATA  ({oRD_EN, oRD_ADDR_0, oRD_ADDR_1}),
    .oDATA  (dl_q)
  );

  assign oWR_EN     = dl_q[DW-1];
  assign oWR_ADDR_0 = dl_q[2*N_LOG2-1:N_LOG2];
  assign oWR_ADDR_1 = dl_q[N_LOG2-1:0];
  assign oBUSY      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign oDONE      = (state_q == ST_DONE);

endmodule

// File: tb/tb_fht_stage_seq.sv
// Directed bench for fht_stage_seq (N_LOG2=4, PIPE=3).
// Cycle n of a capture = value seen n clocks after iSTART is sampled.
module tb_fht_stage_seq;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] stage;
  logic       busy, done, err, rd_en, rd_bank, wr_en;
  logic [3:0] ra0, ra1, ra2, wa0, wa1;
  logic [2:0] tw;

  always #5 clk = ~clk;

  fht_stage_seq dut (
    .iCLK       (clk),
    .iRESET     (rst),
    .iSTART     (start),
    .iSTAGE     (stage),
    .oBUSY      (busy),
    .oDONE      (done),
    .oERR       (err),
    .oRD_EN     (rd_en),
    .oRD_BANK   (rd_bank),
    .oRD_ADDR_0 (ra0),
    .oRD_ADDR_1 (ra1),
    .oRD_ADDR_2 (ra2),
    .oTW_ADDR   (tw),
    .oWR_EN     (wr_en),
    .oWR_ADDR_0 (wa0),
    .oWR_ADDR_1 (wa1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic       c_rd[32], c_wr[32], c_done[32];
  logic       c_busy[32], c_err[32], c_bank[32];
  logic [3:0] c_a0[32], c_a1[32], c_a2[32];
  logic [3:0] c_w0[32], c_w1[32];
  logic [2:0] c_tw[32];

  task automatic capture(input logic [2:0] s, input int ncyc,
                         input int pulse_at, input logic [2:0] pulse_s,
                         input int reset_at);
    @(negedge clk);
    start = 1'b1;
    stage = s;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      c_rd[n]   = rd_en;   c_wr[n]   = wr_en;
      c_done[n] = done;    c_busy[n] = busy;
      c_err[n]  = err;     c_bank[n] = rd_bank;
      c_a0[n]   = ra0;     c_a1[n]   = ra1;
      c_a2[n]   = ra2;     c_tw[n]   = tw;
      c_w0[n]   = wa0;     c_w1[n]   = wa1;
      if (n == pulse_at) begin
        start = 1'b1;
        stage = pulse_s;
      end
      if (n == reset_at) rst = 1'b1;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [34:0] o;
    rst = 1'b1; start = 1'b0; stage = '0;
    repeat (3) @(negedge clk);
    o = {busy, done, err, rd_en, rd_bank, wr_en, ra0, ra1, ra2, tw, wa0, wa1};
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h want=0", o);
    end
    rst = 1'b0;
    idle(2);
    o = {busy, done, err, rd_en, rd_bank, wr_en, ra0, ra1, ra2, tw, wa0, wa1};
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL idle_outputs got=%h want=0", o);
    end
  endtask

  task automatic test_stage1();
    logic [31:0] e0 = 32'hDC985410;
    logic [31:0] e1 = 32'hFEBA7632;
    logic [31:0] et = 32'h40404040;
    logic [3:0]  got, exp;
    logic [16:0] ga, xa;
    capture(3'd1, 14, 0, 3'd0, 0);
    for (int n = 1; n <= 14; n++) begin
      got = {c_rd[n], c_wr[n], c_done[n], c_busy[n]};
      exp = {n <= 8, n >= 4 && n <= 11, n == 12, n <= 11};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL s1_timing n=%0d got=%b want=%b", n, got, exp);
      end
    end
    for (int j = 0; j < 8; j++) begin
      ga = {c_a0[j+1], c_a1[j+1], c_a2[j+1], 1'b0, c_tw[j+1], c_bank[j+1]};
      xa = {e0[j*4 +: 4], e1[j*4 +: 4], e1[j*4 +: 4], et[j*4 +: 4], 1'b1};
      n_cmp++;
      if (ga !== xa) begin
        n_bad++;
        $display("FAIL s1_rd j=%0d got=%h want=%h", j, ga, xa);
      end
      n_cmp++;
      if ({c_w0[j+4], c_w1[j+4]} !== {e0[j*4 +: 4], e1[j*4 +: 4]}) begin
        n_bad++;
        $display("FAIL s1_wr j=%0d got=%h%h want=%h%h", j, c_w0[j+4],
                 c_w1[j+4], e0[j*4 +: 4], e1[j*4 +: 4]);
      end
    end
    for (int n = 9; n <= 14; n++) begin
      ga = {c_a0[n], c_a1[n], c_a2[n], 1'b0, c_tw[n], c_bank[n]};
      n_cmp++;
      if (ga !== '0) begin
        n_bad++;
        $display("FAIL s1_rd_zero n=%0d got=%h want=0", n, ga);
      end
    end
    for (int n = 12; n <= 14; n++) begin
      n_cmp++;
      if ({c_w0[n], c_w1[n]} !== 8'h00) begin
        n_bad++;
        $display("FAIL s1_wr_zero n=%0d got=%h%h want=00", n, c_w0[n], c_w1[n]);
      end
    end
    idle(2);
  endtask

  task automatic test_stage3();
    logic [31:0] e0 = 32'h76543210;
    logic [31:0] e1 = 32'hFEDCBA98;
    logic [31:0] e2 = 32'h9ABCDEF8;
    logic [16:0] ga, xa;
    capture(3'd3, 14, 0, 3'd0, 0);
    for (int j = 0; j < 8; j++) begin
      ga = {c_a0[j+1], c_a1[j+1], c_a2[j+1], 1'b0, c_tw[j+1], c_bank[j+1]};
      xa = {e0[j*4 +: 4], e1[j*4 +: 4], e2[j*4 +: 4], e0[j*4 +: 4], 1'b1};
      n_cmp++;
      if (ga !== xa) begin
        n_bad++;
        $display("FAIL s3_rd j=%0d got=%h want=%h", j, ga, xa);
      end
      n_cmp++;
      if ({c_wr[j+4], c_w0[j+4], c_w1[j+4]} !== {1'b1, e0[j*4 +: 4], e1[j*4 +: 4]}) begin
        n_bad++;
        $display("FAIL s3_wr j=%0d got=%b%h%h", j, c_wr[j+4], c_w0[j+4], c_w1[j+4]);
      end
    end
    n_cmp++;
    if (c_done[12] !== 1'b1 || c_busy[12] !== 1'b0) begin
      n_bad++;
      $display("FAIL s3_done got=%b%b want=10", c_done[12], c_busy[12]);
    end
    idle(2);
  endtask

  task automatic test_stage0();
    logic [16:0] ga, xa;
    logic [3:0]  x;
    capture(3'd0, 14, 0, 3'd0, 0);
    for (int j = 0; j < 8; j++) begin
      x  = 4'(2 * j);
      ga = {c_rd[j+1], c_a0[j+1], c_a1[j+1], c_a2[j+1], c_tw[j+1], c_bank[j+1]};
      xa = {1'b1, x, x + 4'd1, x + 4'd1, 3'd0, 1'b0};
      n_cmp++;
      if (ga !== xa) begin
        n_bad++;
        $display("FAIL s0_rd j=%0d got=%h want=%h", j, ga, xa);
      end
    end
    idle(2);
  endtask

  task automatic test_start_in_run();
    int nr, nw, nd;
    capture(3'd1, 16, 3, 3'd0, 0);
    nr = 0; nw = 0; nd = 0;
    for (int n = 1; n <= 16; n++) begin
      nr += int'(c_rd[n]);
      nw += int'(c_wr[n]);
      nd += int'(c_done[n]);
    end
    n_cmp++;
    if (nr != 8 || nw != 8 || nd != 1) begin
      n_bad++;
      $display("FAIL run_restart got rd=%0d wr=%0d done=%0d want 8 8 1", nr, nw, nd);
    end
    n_cmp++;
    if ({c_a0[6], c_bank[6]} !== {4'd9, 1'b1}) begin
      n_bad++;
      $display("FAIL run_stage_kept got=%h,%b want=9,1", c_a0[6], c_bank[6]);
    end
    idle(2);
  endtask

  task automatic test_err();
    logic [2:0] got;
    capture(3'd4, 5, 0, 3'd0, 0);
    for (int n = 1; n <= 5; n++) begin
      got = {c_err[n], c_rd[n], c_busy[n]};
      n_cmp++;
      if (got !== {n == 1, 2'b00}) begin
        n_bad++;
        $display("FAIL err_stage n=%0d got=%b want=%b", n, got, {n == 1, 2'b00});
      end
    end
    idle(2);
  endtask

  task automatic test_mid_reset();
    logic [34:0] o;
    int nr, nw, nd;
    capture(3'd1, 12, 0, 3'd0, 5);
    n_cmp++;
    if ({c_rd[5], c_wr[5], c_a0[5], c_w0[5]} !== {1'b1, 1'b1, 4'd8, 4'd1}) begin
      n_bad++;
      $display("FAIL mrst_pre got=%b%b%h%h want=11 8 1", c_rd[5], c_wr[5], c_a0[5], c_w0[5]);
    end
    for (int n = 6; n <= 12; n++) begin
      o = {c_busy[n], c_done[n], c_err[n], c_rd[n], c_bank[n], c_wr[n],
           c_a0[n], c_a1[n], c_a2[n], c_tw[n], c_w0[n], c_w1[n]};
      n_cmp++;
      if (o !== '0) begin
        n_bad++;
        $display("FAIL mrst_zero n=%0d got=%h want=0", n, o);
      end
    end
    capture(3'd3, 14, 0, 3'd0, 0);
    nr = 0; nw = 0; nd = 0;
    for (int n = 1; n <= 14; n++) begin
      nr += int'(c_rd[n]);
      nw += int'(c_wr[n]);
      nd += int'(c_done[n]);
    end
    n_cmp++;
    if (nr != 8 || nw != 8 || nd != 1 || c_a2[2] !== 4'd15) begin
      n_bad++;
      $display("FAIL mrst_rerun got rd=%0d wr=%0d done=%0d x2=%0d", nr, nw, nd, c_a2[2]);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int nr;
    capture(3'd2, 20, 12, 3'd2, 0);
    nr = 0;
    for (int n = 1; n <= 20; n++) nr += int'(c_rd[n]);
    n_cmp++;
    if (nr != 8) begin
      n_bad++;
      $display("FAIL b2b_early got rd=%0d want=8", nr);
    end
    idle(2);
    capture(3'd2, 22, 13, 3'd3, 0);
    nr = 0;
    for (int n = 1; n <= 22; n++) nr += int'(c_rd[n]);
    n_cmp++;
    if (nr != 16 || c_rd[14] !== 1'b1 || c_a1[16] !== 4'd10) begin
      n_bad++;
      $display("FAIL b2b_next got rd=%0d rd14=%b x1=%0d want 16 1 10",
               nr, c_rd[14], c_a1[16]);
    end
    idle(16);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stage = '0;
    test_reset();
    test_stage1();
    test_stage3();
    test_stage0();
    test_start_in_run();
    test_err();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
